xadc_drp_sequencer: RTL and testbench

Round-robin controller for the XADC dynamic reconfiguration port (DRP). It repeatedly reads a programmable list of status-register addresses, such as the VP/VN channel at 0x03 and the auxiliary channels. It also interleaves one-shot configuration writes and keeps the latest 12-bit conversion per channel. It sits between the `xadc_wiz_0` instance and the consumers of pot/sensor values, replacing free-running `den` tie-offs with a proper handshake.

---
 rtl/xadc_pkg.sv | 26 ++
 rtl/drp_watchdog.sv | 29 ++
 rtl/xadc_drp_sequencer.sv | 121 ++++++++++++
 tb/tb_xadc_drp_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC DRP sequencer.
// Latency: none (definitions only).
// Backpressure: not applicable.
package xadc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE_RD = 2'd1,
    ST_ISSUE_WR = 2'd2,
    ST_WAIT     = 2'd3
  } drp_state_t;

  localparam int DRP_ADDR_W = 7;
  localparam int DRP_DATA_W = 16;
  localparam int ADC_RES_W  = 12;

  localparam logic [DRP_ADDR_W-1:0] XADC_ADDR_VPVN      = 7'h03;
  localparam logic [DRP_ADDR_W-1:0] XADC_ADDR_AUX_FIRST = 7'h10;
  localparam logic [DRP_ADDR_W-1:0] XADC_ADDR_AUX_LAST  = 7'h1F;

  // Status-register address of auxiliary channel n (0..15).
  function automatic logic [DRP_ADDR_W-1:0] xadc_aux_addr(input logic [3:0] n);
    return XADC_ADDR_AUX_FIRST | {3'b000, n};
  endfunction

endpackage

// File: rtl/drp_watchdog.sv
// Cycle watchdog for one outstanding DRP transaction.
// Latency: expired is combinational from the count; count advances once per run cycle.
// Backpressure: none; clear takes priority over run, count saturates at TIMEOUT.
module drp_watchdog #(
  parameter int TIMEOUT = 63
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [7:0] count;

  // Count WAIT cycles from zero, holding at the limit until cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (run && (count != 8'(TIMEOUT))) begin
      count <= count + 8'd1;
    end
  end

  assign expired = run && (count == 8'(TIMEOUT));

endmodule

// File: rtl/xadc_drp_sequencer.sv
// Round-robin XADC DRP poller with interleaved one-shot config writes and per-slot result registers.
// Latency: den one cycle after IDLE decision; result/ack visible the cycle after drdy is sampled.
// Backpressure: one DRP transaction outstanding; cfg_req is held by the requester until cfg_ack.
module xadc_drp_sequencer
  import xadc_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 63
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_CH*DRP_ADDR_W-1:0]  ch_addr,
  input  logic                          cfg_req,
  input  logic [DRP_ADDR_W-1:0]         cfg_addr,
  input  logic [DRP_DATA_W-1:0]         cfg_data,
  output logic                          cfg_ack,
  output logic [DRP_ADDR_W-1:0]         drp_daddr,
  output logic                          drp_den,
  output logic                          drp_dwe,
  output logic [DRP_DATA_W-1:0]         drp_di,
  input  logic [DRP_DATA_W-1:0]         drp_do,
  input  logic                          drp_drdy,
  output logic [NUM_CH*ADC_RES_W-1:0]   result,
  output logic                          result_valid,
  output logic [2:0]                    result_ch,
  output logic                          timeout_err
);

  localparam logic [2:0] LAST_SLOT = 3'(NUM_CH - 1);

  drp_state_t state;
  logic [2:0] slot;
  logic [2:0] next_slot;
  logic       is_wr;
  logic       expired;

  // The low nibble of DO sits below the ADC resolution and is dropped.
  logic unused_do_lsbs;
  assign unused_do_lsbs = ^drp_do[3:0];

  assign next_slot = (slot == LAST_SLOT) ? 3'd0 : slot + 3'd1;

  drp_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != ST_WAIT),
    .run     (state == ST_WAIT),
    .expired (expired)
  );

  // Sequencer FSM; every DRP and result output is registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      slot         <= 3'd0;
      is_wr        <= 1'b0;
      cfg_ack      <= 1'b0;
      drp_daddr    <= '0;
      drp_den      <= 1'b0;
      drp_dwe      <= 1'b0;
      drp_di       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      result_ch    <= 3'd0;
      timeout_err  <= 1'b0;
    end else begin
      drp_den      <= 1'b0;
      drp_dwe      <= 1'b0;
      cfg_ack      <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          // cfg_req is still high in the cycle cfg_ack is shown; skip it then
          // so a single request never produces a second write.
          if (cfg_req && !cfg_ack) begin
            state     <= ST_ISSUE_WR;
            is_wr     <= 1'b1;
            drp_den   <= 1'b1;
            drp_dwe   <= 1'b1;
            drp_daddr <= cfg_addr;
            drp_di    <= cfg_data;
          end else if (enable) begin
            // Address is captured on the edge into ISSUE_RD and held through it.
            state     <= ST_ISSUE_RD;
            is_wr     <= 1'b0;
            drp_den   <= 1'b1;
            drp_daddr <= ch_addr[slot*DRP_ADDR_W +: DRP_ADDR_W];
          end
        end
        ST_ISSUE_RD, ST_ISSUE_WR: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // drdy beats the watchdog when both land in the same cycle.
          if (drp_drdy) begin
            state <= ST_IDLE;
            if (is_wr) begin
              cfg_ack <= 1'b1;
            end else begin
              result[slot*ADC_RES_W +: ADC_RES_W] <= drp_do[15:4];
              result_ch    <= slot;
              result_valid <= 1'b1;
              slot         <= next_slot;
            end
          end else if (expired) begin
            state       <= ST_IDLE;
            timeout_err <= 1'b1;
            if (is_wr) begin
              cfg_ack <= 1'b1;
            end else begin
              slot <= next_slot;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
module tb_xadc_drp_sequencer;

  localparam int NUM_CH  = 2;
  localparam int TIMEOUT = 63;

  logic                 clk;
  logic                 reset;
  logic                 enable;
  logic [NUM_CH*7-1:0]  ch_addr;
  logic                 cfg_req;
  logic [6:0]           cfg_addr;
  logic [15:0]          cfg_data;
  logic                 cfg_ack;
  logic [6:0]           drp_daddr;
  logic                 drp_den;
  logic                 drp_dwe;
  logic [15:0]          drp_di;
  logic [15:0]          drp_do;
  logic                 drp_drdy;
  logic [NUM_CH*12-1:0] result;
  logic                 result_valid;
  logic [2:0]           result_ch;
  logic                 timeout_err;

  xadc_drp_sequencer #(.NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .ch_addr      (ch_addr),
    .cfg_req      (cfg_req),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cfg_ack      (cfg_ack),
    .drp_daddr    (drp_daddr),
    .drp_den      (drp_den),
    .drp_dwe      (drp_dwe),
    .drp_di       (drp_di),
    .drp_do       (drp_do),
    .drp_drdy     (drp_drdy),
    .result       (result),
    .result_valid (result_valid),
    .result_ch    (result_ch),
    .timeout_err  (timeout_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int den_total = 0;
  int ack_total = 0;
  int rv_total = 0;
  bit prev_den = 1'b0;

  int          resp_lat = 3;
  logic [15:0] resp_data = 16'h0;
  bit          resp_none = 1'b0;
  logic [11:0] exp_res [NUM_CH];

  typedef struct {
    int          lat;
    logic [15:0] data;
    logic [6:0]  addr;
    logic [2:0]  ch;
    logic [11:0] val;
  } vec_t;

  vec_t tbl [6];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Protocol monitor: den single-cycle, dwe only with den, event counters.
  always @(negedge clk) begin
    if (!reset) begin
      if (drp_den) begin
        check("den_single_cycle", {31'b0, prev_den}, 0);
        den_total++;
      end
      if (drp_dwe) check("dwe_only_with_den", {31'b0, drp_den}, 1);
      if (cfg_ack) ack_total++;
      if (result_valid) rv_total++;
      prev_den = drp_den;
    end
  end

  // Behavioural XADC: drdy appears resp_lat cycles after the den cycle.
  initial begin
    int          l;
    logic [15:0] d;
    drp_drdy = 1'b0;
    drp_do   = 16'h0;
    forever begin
      @(negedge clk);
      if (drp_den && !reset && !resp_none) begin
        l = resp_lat;
        d = resp_data;
        repeat (l) @(posedge clk);
        #1;
        drp_drdy = 1'b1;
        drp_do   = d;
        @(posedge clk);
        #1;
        drp_drdy = 1'b0;
      end
    end
  end

  // which: 0 = drp_den, 1 = result_valid, 2 = cfg_ack
  task automatic wait_for(input int which, input int lim, input string name, output bit ok);
    int i;
    ok = 1'b0;
    i = 0;
    while (!ok && i < lim) begin
      @(negedge clk);
      if ((which == 0 && drp_den) || (which == 1 && result_valid) || (which == 2 && cfg_ack))
        ok = 1'b1;
      i++;
    end
    check(name, {31'b0, ok}, 1);
  endtask

  task automatic do_read(input logic [6:0] exp_addr, input int lat, input logic [15:0] data,
                         input logic [2:0] exp_ch, input logic [11:0] exp_val, output int den_at);
    bit ok;
    int other;
    resp_lat  = lat;
    resp_data = data;
    resp_none = 1'b0;
    wait_for(0, 300, "rd_den_seen", ok);
    den_at = cyc;
    if (ok) begin
      check("rd_daddr", {25'b0, drp_daddr}, {25'b0, exp_addr});
      check("rd_dwe", {31'b0, drp_dwe}, 0);
      wait_for(1, 300, "rd_valid_seen", ok);
      if (ok) begin
        check("rd_latency", cyc - den_at, lat + 1);
        check("rd_result_ch", {29'b0, result_ch}, {29'b0, exp_ch});
        check("rd_result_val", {20'b0, result[int'(exp_ch)*12 +: 12]}, {20'b0, exp_val});
        exp_res[exp_ch] = exp_val;
        other = 1 - int'(exp_ch);
        check("rd_other_slot", {20'b0, result[other*12 +: 12]}, {20'b0, exp_res[other]});
      end
    end
  endtask

  initial begin
    bit ok;
    int t, t2, en_cyc, rv0, d0;

    tbl[0] = '{lat: 3, data: 16'hABC0, addr: 7'h03, ch: 3'd0, val: 12'hABC};
    tbl[1] = '{lat: 1, data: 16'h1235, addr: 7'h10, ch: 3'd1, val: 12'h123};
    tbl[2] = '{lat: 2, data: 16'hFFFF, addr: 7'h03, ch: 3'd0, val: 12'hFFF};
    tbl[3] = '{lat: 5, data: 16'h000F, addr: 7'h10, ch: 3'd1, val: 12'h000};
    tbl[4] = '{lat: 1, data: 16'h8001, addr: 7'h03, ch: 3'd0, val: 12'h800};
    tbl[5] = '{lat: 4, data: 16'h5A5A, addr: 7'h10, ch: 3'd1, val: 12'h5A5};
    exp_res[0] = 12'h0;
    exp_res[1] = 12'h0;

    reset    = 1'b1;
    enable   = 1'b0;
    ch_addr  = {7'h10, 7'h03};
    cfg_req  = 1'b0;
    cfg_addr = 7'h0;
    cfg_data = 16'h0;
    repeat (2) @(negedge clk);
    check("rst_den", {31'b0, drp_den}, 0);
    check("rst_result", {8'b0, result}, 0);
    check("rst_valid", {31'b0, result_valid}, 0);
    check("rst_timeout_err", {31'b0, timeout_err}, 0);
    check("rst_daddr", {25'b0, drp_daddr}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Polling table; enable rises just before the first entry.
    enable = 1'b1;
    en_cyc = cyc;
    for (int i = 0; i < 6; i++) begin
      do_read(tbl[i].addr, tbl[i].lat, tbl[i].data, tbl[i].ch, tbl[i].val, t);
      if (i == 0) check("enable_to_den", t - en_cyc, 1);
    end

    // Config write requested mid-read: read completes, then write, then slot 1.
    resp_lat  = 3;
    resp_data = 16'h4440;
    wait_for(0, 300, "a_rd_den_seen", ok);
    check("a_rd_daddr", {25'b0, drp_daddr}, 32'h03);
    cfg_addr = 7'h41;
    cfg_data = 16'h2000;
    cfg_req  = 1'b1;
    wait_for(1, 300, "a_rd_valid_seen", ok);
    check("a_rd_ch", {29'b0, result_ch}, 0);
    check("a_rd_val", {20'b0, result[11:0]}, 32'h444);
    exp_res[0] = 12'h444;
    wait_for(0, 20, "a_wr_den_seen", ok);
    rv0 = rv_total;
    check("a_wr_dwe", {31'b0, drp_dwe}, 1);
    check("a_wr_daddr", {25'b0, drp_daddr}, 32'h41);
    check("a_wr_di", {16'b0, drp_di}, 32'h2000);
    wait_for(2, 300, "a_ack_seen", ok);
    cfg_req = 1'b0;
    check("a_no_valid_on_write", rv_total, rv0);
    do_read(7'h10, 2, 16'h0450, 3'd1, 12'h045, t);
    check("a_ack_once", ack_total, 1);

    // drdy lands exactly on the watchdog expiry cycle.
    do_read(7'h03, TIMEOUT + 1, 16'h7770, 3'd0, 12'h777, t);
    check("c_no_timeout_err", {31'b0, timeout_err}, 0);
    do_read(7'h10, 2, 16'h0100, 3'd1, 12'h010, t);

    // Slot 0 never answers: timeout after TIMEOUT+1 WAIT cycles, then slot 1.
    resp_none = 1'b1;
    wait_for(0, 300, "b_den_seen", ok);
    t = cyc;
    rv0 = rv_total;
    check("b_daddr", {25'b0, drp_daddr}, 32'h03);
    for (int k = 1; k <= 65; k++) begin
      @(negedge clk);
      if (k == 64) check("b_err_before_expiry", {31'b0, timeout_err}, 0);
      if (k == 65) begin
        check("b_err_after_expiry", {31'b0, timeout_err}, 1);
        resp_none = 1'b0;
      end
    end
    check("b_no_valid", rv_total, rv0);
    check("b_result0_kept", {20'b0, result[11:0]}, 32'h777);
    do_read(7'h10, 2, 16'h3210, 3'd1, 12'h321, t2);
    check("b_next_den_gap", t2 - t, 66);

    // enable drops during WAIT: read completes, block parks, resumes at slot 1.
    resp_lat  = 4;
    resp_data = 16'h0AB0;
    wait_for(0, 300, "d_den_seen", ok);
    check("d_daddr", {25'b0, drp_daddr}, 32'h03);
    @(negedge clk);
    enable = 1'b0;
    wait_for(1, 300, "d_valid_seen", ok);
    check("d_ch", {29'b0, result_ch}, 0);
    check("d_val", {20'b0, result[11:0]}, 32'h0AB);
    exp_res[0] = 12'h0AB;
    @(negedge clk);
    d0 = den_total;
    repeat (20) @(negedge clk);
    check("d_parked", den_total, d0);
    enable = 1'b1;
    do_read(7'h10, 1, 16'h0110, 3'd1, 12'h011, t);

    // Async reset mid-WAIT; the late drdy after release must be ignored.
    resp_lat  = 6;
    resp_data = 16'hEEE0;
    wait_for(0, 300, "e_den_seen", ok);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("e_rst_den", {31'b0, drp_den}, 0);
    check("e_rst_dwe", {31'b0, drp_dwe}, 0);
    check("e_rst_daddr", {25'b0, drp_daddr}, 0);
    check("e_rst_di", {16'b0, drp_di}, 0);
    check("e_rst_result", {8'b0, result}, 0);
    check("e_rst_timeout_err", {31'b0, timeout_err}, 0);
    check("e_rst_valid", {31'b0, result_valid}, 0);
    check("e_rst_ch", {29'b0, result_ch}, 0);
    check("e_rst_ack", {31'b0, cfg_ack}, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_res[0] = 12'h0;
    exp_res[1] = 12'h0;
    rv0 = rv_total;
    repeat (12) @(negedge clk);
    check("e_late_drdy_ignored", rv_total, rv0);
    check("e_result_still_zero", {8'b0, result}, 0);
    enable = 1'b1;
    do_read(7'h03, 2, 16'h0C30, 3'd0, 12'h0C3, t);
    enable = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
